// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares single-port DMEM between core (m0) and loader (m1).
// Round-robin with a burst cap; zero-latency grant, 1-cycle read return.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } own_e;

    own_e              own_q;
    own_e              gsel;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_inc;
    logic              tag0_q;
    logic              tag1_q;
    logic              we_q;
    logic [ADDR_W-3:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sel_we;
    logic [ADDR_W-3:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              unused_ok;

    assign unused_ok = ^{m0_addr[1:0], m1_addr[1:0]};

    // Grant decision: owner keeps the port until its burst is used up.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst) begin
            if (m0_req && m1_req) begin
                if (cnt_q < CNT_MAX) begin
                    m0_gnt = (own_q == OWN_M0);
                    m1_gnt = (own_q == OWN_M1);
                end else begin
                    m0_gnt = (own_q == OWN_M1);
                    m1_gnt = (own_q == OWN_M0);
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Selected requester fields and saturating burst increment.
    always_comb begin
        gsel      = m1_gnt ? OWN_M1 : OWN_M0;
        sel_we    = m1_gnt ? m1_we : m0_we;
        sel_addr  = m1_gnt ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
        sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
        cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end

    // Owner FSM and burst counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_q <= OWN_M0;
            cnt_q <= '0;
        end else if (m0_gnt || m1_gnt) begin
            if (gsel == own_q) begin
                cnt_q <= cnt_inc;
            end else begin
                own_q <= gsel;
                cnt_q <= CNT_ONE;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // Read-return tags and held memory command fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag0_q  <= 1'b0;
            tag1_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            tag0_q <= m0_gnt && !m0_we;
            tag1_q <= m1_gnt && !m1_we;
            if (mem_en) begin
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    assign mem_en    = m0_gnt | m1_gnt;
    assign mem_we    = mem_en ? sel_we : we_q;
    assign mem_addr  = mem_en ? sel_addr : addr_q;
    assign mem_wdata = mem_en ? sel_wdata : wdata_q;
    assign m0_rvalid = tag0_q;
    assign m1_rvalid = tag1_q;
    assign m0_rdata  = tag0_q ? mem_rdata : '0;
    assign m1_rdata  = tag1_q ? mem_rdata : '0;
    assign owner     = own_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with a behavioural sync DMEM.
// Expected read data comes from a bench-side shadow of issued writes.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        owner;

    logic [31:0] dmem   [0:255];
    logic [31:0] shadow [0:255];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= dmem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r0, input logic w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic eg0, input logic eg1, input int eown);
        @(negedge clk);
        if (eown >= 0) chk("owner", {31'b0, owner}, eown[31:0]);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, q0.size() != 0});
        if (q0.size() != 0) chk("m0_rdata", m0_rdata, q0.pop_front());
        else                chk("m0_rdata_idle", m0_rdata, 32'h0);
        chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, q1.size() != 0});
        if (q1.size() != 0) chk("m1_rdata", m1_rdata, q1.pop_front());
        else                chk("m1_rdata_idle", m1_rdata, 32'h0);
        chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, eg0});
        chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, eg1});
        chk("mem_en", {31'b0, mem_en}, {31'b0, eg0 | eg1});
        if (eg0) begin
            chk("mem_we0", {31'b0, mem_we}, {31'b0, w0});
            chk("mem_addr0", {2'b0, mem_addr}, a0 >> 2);
            if (w0) begin
                chk("mem_wdata0", mem_wdata, d0);
                shadow[a0[9:2]] = d0;
            end else q0.push_back(shadow[a0[9:2]]);
        end
        if (eg1) begin
            chk("mem_we1", {31'b0, mem_we}, {31'b0, w1});
            chk("mem_addr1", {2'b0, mem_addr}, a1 >> 2);
            if (w1) begin
                chk("mem_wdata1", mem_wdata, d1);
                shadow[a1[9:2]] = d1;
            end else q1.push_back(shadow[a1[9:2]]);
        end
    endtask

    task automatic idle(input int eown);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eown);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b0;
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m0_req = 1; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 1; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        mem_rdata = '0;
        @(negedge clk); #1;
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 0);
        chk("rst_m1_gnt", {31'b0, m1_gnt}, 0);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_owner", {31'b0, owner}, 0);
        chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
        chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 0);
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        rst = 1'b1;

        // loader preload, core reads back
        cyc(0, 0, 0, 0, 1, 1, 40, 32'hABCDEF01, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1, 80, 32'h12345678, 0, 1, 1);
        cyc(1, 0, 40, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 80, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(0);

        // continuous contention from reset
        rst_pulse();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 40, 0, 1, 0, 80, 0,
                (i < 4) || (i >= 8), (i >= 4) && (i < 8),
                (i <= 4) ? 0 : ((i <= 8) ? 1 : 0));
        end
        idle(0);

        // m1 alone saturates, then m0 wins at once
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 1, 1, 100 + 4 * i, 32'h5000 + i,
                0, 1, (i == 0) ? 0 : 1);
        end
        cyc(1, 0, 100, 0, 1, 0, 104, 0, 1, 0, 1);
        cyc(1, 0, 136, 0, 1, 0, 108, 0, 1, 0, 0);
        idle(0);

        // idle gap keeps last owner
        cyc(0, 0, 0, 0, 1, 0, 40, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 80, 0, 0, 1, 1);
        idle(1);
        cyc(1, 0, 40, 0, 1, 0, 80, 0, 0, 1, 1);
        idle(1);

        // word write, byte offset ignored on read
        cyc(1, 1, 12, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, -1);
        cyc(1, 0, 13, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(0);
        chk("hold_addr", {2'b0, mem_addr}, 32'd3);
        chk("hold_we", {31'b0, mem_we}, 0);

        // reset during a pending read
        cyc(1, 0, 40, 0, 0, 0, 0, 0, 1, 0, 0);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_rvalid", {31'b0, m0_rvalid}, 0);
        chk("rstmid_owner", {31'b0, owner}, 0);
        chk("rstmid_mem_en", {31'b0, mem_en}, 0);
        chk("rstmid_gnt", {31'b0, m0_gnt}, 0);
        q0.delete();
        m0_req = 0;
        rst = 1'b1;
        idle(0);
        cyc(1, 0, 40, 0, 1, 0, 80, 0, 1, 0, 0);
        idle(0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
